// File: rtl/jesd204b_tx_pkg.sv
// Shared constants for the JESD204B TX link layer: link phase encoding and control characters.
package jesd204b_tx_pkg;

    localparam logic [1:0] PH_CGS  = 2'd0;
    localparam logic [1:0] PH_WAIT = 2'd1;
    localparam logic [1:0] PH_ILAS = 2'd2;
    localparam logic [1:0] PH_DATA = 2'd3;

    // 8b/10b control characters inserted by the data-link octet mux
    localparam logic [7:0] K28_5_CHAR = 8'hBC;
    localparam logic [7:0] K28_0_R    = 8'h1C;
    localparam logic [7:0] K28_3_A    = 8'h7C;
    localparam logic [7:0] K28_4_Q    = 8'h9C;

    typedef enum logic [1:0] {
        StCgs  = PH_CGS,
        StWait = PH_WAIT,
        StIlas = PH_ILAS,
        StData = PH_DATA
    } link_state_e;

endpackage

// File: rtl/jesd204b_lmfc_cnt.sv
// LMFC (multiframe) frame counter. With JESD_TX_SYSREF_EN defined, a synchronised SYSREF
// rising edge realigns the counter to frame 0.
module jesd204b_lmfc_cnt #(
    parameter int unsigned K_FRAMES = 32,
    parameter int unsigned CNT_W    = $clog2(K_FRAMES)
) (
    input  logic             clk,
    input  logic             reset,
`ifdef JESD_TX_SYSREF_EN
    input  logic             sysref,
    output logic             realign,
`endif
    output logic [CNT_W-1:0] lmfc_cnt,
    output logic             lmfc_wrap
);

    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(K_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef JESD_TX_SYSREF_EN
    logic sysref_meta_q, sysref_s_q, sysref_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sysref_meta_q <= 1'b0;
            sysref_s_q    <= 1'b0;
            sysref_prev_q <= 1'b0;
        end else begin
            sysref_meta_q <= sysref;
            sysref_s_q    <= sysref_meta_q;
            sysref_prev_q <= sysref_s_q;
        end
    end

    assign realign = sysref_s_q & ~sysref_prev_q;
`endif

    assign lmfc_wrap = (cnt_q == LAST_FRAME);
    assign lmfc_cnt  = cnt_q;

    always_comb begin
        cnt_d = lmfc_wrap ? '0 : cnt_q + 1'b1;
`ifdef JESD_TX_SYSREF_EN
        if (realign) cnt_d = '0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B TX link sequencer (CGS -> WAIT_LMFC -> ILAS -> DATA) driven by SYNC~.
// Optional SYSREF realignment is enabled by defining JESD_TX_SYSREF_EN.
module jesd204b_tx_link_ctrl
    import jesd204b_tx_pkg::*;
#(
    parameter int unsigned K_FRAMES    = 32,
    parameter int unsigned ILAS_MF     = 4,
    parameter int unsigned SYNC_ERR_FR = 4,
    localparam int unsigned CNT_W      = $clog2(K_FRAMES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_n,
    input  logic             sysref,
    output logic             tpl_en,
    output logic             k_char_en,
    output logic             ilas_r,
    output logic             ilas_a,
    output logic             ilas_q,
    output logic [1:0]       link_phase,
    output logic [CNT_W-1:0] lmfc_cnt,
    output logic [7:0]       resync_cnt
);

    localparam logic [1:0] MF_LAST  = 2'(ILAS_MF - 1);
    localparam logic [3:0] LOW_LAST = 4'(SYNC_ERR_FR - 1);

    link_state_e state_q, state_d;
    logic [1:0]  mf_q, mf_d;
    logic [3:0]  low_q, low_d;
    logic [7:0]  resync_q, resync_d;
    logic        sync_meta_q, sync_s;
    logic        lmfc_wrap;
    logic        realign;
    logic        drop;

`ifdef JESD_TX_SYSREF_EN
    jesd204b_lmfc_cnt #(
        .K_FRAMES (K_FRAMES),
        .CNT_W    (CNT_W)
    ) u_lmfc (
        .clk       (clk),
        .reset     (reset),
        .sysref    (sysref),
        .realign   (realign),
        .lmfc_cnt  (lmfc_cnt),
        .lmfc_wrap (lmfc_wrap)
    );
`else
    logic unused_sysref;
    assign unused_sysref = sysref;
    assign realign       = 1'b0;

    jesd204b_lmfc_cnt #(
        .K_FRAMES (K_FRAMES),
        .CNT_W    (CNT_W)
    ) u_lmfc (
        .clk       (clk),
        .reset     (reset),
        .lmfc_cnt  (lmfc_cnt),
        .lmfc_wrap (lmfc_wrap)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta_q <= 1'b0;
            sync_s      <= 1'b0;
        end else begin
            sync_meta_q <= sync_n;
            sync_s      <= sync_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        mf_d     = mf_q;
        low_d    = '0;
        resync_d = resync_q;
        drop     = 1'b0;

        if ((state_q == StIlas || state_q == StData) && !sync_s) begin
            if (low_q == LOW_LAST) drop = 1'b1;
            else                   low_d = low_q + 4'd1;
        end

        unique case (state_q)
            StCgs: begin
                if (sync_s) state_d = StWait;
            end
            StWait: begin
                if (!sync_s) begin
                    state_d = StCgs;
                end else if (lmfc_wrap) begin
                    state_d = StIlas;
                    mf_d    = '0;
                end
            end
            StIlas: begin
                // A SYSREF realign restarts the ILAS sequence from its first multiframe
                if (realign) begin
                    mf_d = '0;
                end else if (lmfc_wrap) begin
                    if (mf_q == MF_LAST) begin
                        state_d = StData;
                        mf_d    = '0;
                    end else begin
                        mf_d = mf_q + 2'd1;
                    end
                end
            end
            StData: ;
            default: state_d = StCgs;
        endcase

        // Re-sync overrides every other transition, including ILAS -> DATA
        if (drop) begin
            state_d = StCgs;
            mf_d    = '0;
            if (resync_q != 8'hFF) resync_d = resync_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StCgs;
            mf_q     <= '0;
            low_q    <= '0;
            resync_q <= '0;
        end else begin
            state_q  <= state_d;
            mf_q     <= mf_d;
            low_q    <= low_d;
            resync_q <= resync_d;
        end
    end

    assign link_phase = state_q;
    assign k_char_en  = (state_q == StCgs) || (state_q == StWait);
    assign ilas_r     = (state_q == StIlas) && (lmfc_cnt == '0);
    assign ilas_a     = (state_q == StIlas) && lmfc_wrap;
    assign ilas_q     = (state_q == StIlas) && (mf_q == 2'd1) && (lmfc_cnt == CNT_W'(1));
    // Raised one frame early to cover the mapper's pipeline latency
    assign tpl_en     = (state_q == StData) ||
                        ((state_q == StIlas) && (mf_q == MF_LAST) && lmfc_wrap);
    assign resync_cnt = resync_q;

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// Directed testbench for jesd204b_tx_link_ctrl (K_FRAMES=32, ILAS_MF=4, SYNC_ERR_FR=4).
module tb_jesd204b_tx_link_ctrl;
    import jesd204b_tx_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       sync_n;
    logic       sysref;
    logic       tpl_en, k_char_en, ilas_r, ilas_a, ilas_q;
    logic [1:0] link_phase;
    logic [4:0] lmfc_cnt;
    logic [7:0] resync_cnt;

    int checks = 0;
    int errors = 0;
    int frame  = 0;
    int nr, na, nq, qpos;

    jesd204b_tx_link_ctrl #(
        .K_FRAMES    (32),
        .ILAS_MF     (4),
        .SYNC_ERR_FR (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sync_n     (sync_n),
        .sysref     (sysref),
        .tpl_en     (tpl_en),
        .k_char_en  (k_char_en),
        .ilas_r     (ilas_r),
        .ilas_a     (ilas_a),
        .ilas_q     (ilas_q),
        .link_phase (link_phase),
        .lmfc_cnt   (lmfc_cnt),
        .resync_cnt (resync_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        frame++;
    endtask

    // Advances on the bench's own frame count, then confirms the DUT agrees
    task automatic wait_lmfc(input int v);
        while ((frame % 32) != v) tick();
        check("lmfc_pos", 32'(lmfc_cnt), 32'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; sync_n = 1'b0; sysref = 1'b0;
        #1;
        check("rst_phase", 32'(link_phase), 32'(PH_CGS));
        check("rst_k", 32'(k_char_en), 32'd1);
        check("rst_tpl", 32'(tpl_en), 32'd0);
        check("rst_ilas", {29'd0, ilas_r, ilas_a, ilas_q}, 32'd0);
        check("rst_lmfc", 32'(lmfc_cnt), 32'd0);
        check("rst_resync", 32'(resync_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; frame = 0;

        // 1: held in CGS while SYNC~ is low
        for (int i = 0; i < 100; i++) begin
            tick();
            check("cgs_phase", 32'(link_phase), 32'(PH_CGS));
            check("cgs_k", 32'(k_char_en), 32'd1);
            check("cgs_tpl", 32'(tpl_en), 32'd0);
        end

        // 2: sync release at lmfc 5, WAIT at 8, ILAS at next 0
        wait_lmfc(5);
        sync_n = 1'b1;
        tick(); tick();
        check("cgs_pre_wait", 32'(link_phase), 32'(PH_CGS));
        tick();
        check("wait_entry", 32'(link_phase), 32'(PH_WAIT));
        check("wait_lmfc8", 32'(lmfc_cnt), 32'd8);
        wait_lmfc(31);
        check("wait_hold", 32'(link_phase), 32'(PH_WAIT));
        check("wait_k", 32'(k_char_en), 32'd1);
        tick();
        check("ilas_entry", 32'(link_phase), 32'(PH_ILAS));
        nr = 0; na = 0; nq = 0; qpos = -1;
        for (int i = 0; i < 128; i++) begin
            nr += int'(ilas_r); na += int'(ilas_a); nq += int'(ilas_q);
            if (ilas_q) qpos = i;
            check("ilas_tpl", 32'(tpl_en), 32'(i == 127));
            tick();
        end
        check("ilas_r_cnt", 32'(nr), 32'd4);
        check("ilas_a_cnt", 32'(na), 32'd4);
        check("ilas_q_cnt", 32'(nq), 32'd1);
        check("ilas_q_pos", 32'(qpos), 32'd33);
        check("data_phase", 32'(link_phase), 32'(PH_DATA));
        check("data_tpl", 32'(tpl_en), 32'd1);
        check("data_k", 32'(k_char_en), 32'd0);

        // 3: three low frames tolerated, four force re-sync
        sync_n = 1'b0; repeat (3) tick();
        sync_n = 1'b1; repeat (6) tick();
        check("low3_phase", 32'(link_phase), 32'(PH_DATA));
        check("low3_resync", 32'(resync_cnt), 32'd0);
        wait_lmfc(2);
        sync_n = 1'b0; repeat (4) tick();
        sync_n = 1'b1;
        tick();
        check("low4_pre", 32'(link_phase), 32'(PH_DATA));
        tick();
        check("low4_phase", 32'(link_phase), 32'(PH_CGS));
        check("low4_resync", 32'(resync_cnt), 32'd1);
        check("low4_tpl", 32'(tpl_en), 32'd0);
        check("low4_k", 32'(k_char_en), 32'd1);
        tick();
        check("rewait", 32'(link_phase), 32'(PH_WAIT));

        // 4a: single low frame during WAIT_LMFC
        sync_n = 1'b0; tick();
        sync_n = 1'b1; tick();
        check("wglitch_pre", 32'(link_phase), 32'(PH_WAIT));
        tick();
        check("wglitch_cgs", 32'(link_phase), 32'(PH_CGS));
        tick();
        check("wglitch_rewait", 32'(link_phase), 32'(PH_WAIT));
        wait_lmfc(31);
        tick();
        check("ilas2_entry", 32'(link_phase), 32'(PH_ILAS));

        // 4b: re-sync lands on the final ILAS frame
        repeat (122) tick();
        sync_n = 1'b0; repeat (4) tick();
        sync_n = 1'b1; tick();
        check("last_phase", 32'(link_phase), 32'(PH_ILAS));
        check("last_tpl", 32'(tpl_en), 32'd1);
        check("last_a", 32'(ilas_a), 32'd1);
        tick();
        check("last_drop", 32'(link_phase), 32'(PH_CGS));
        check("last_resync", 32'(resync_cnt), 32'd2);
        check("last_tpl0", 32'(tpl_en), 32'd0);

        // 5: asynchronous reset in ILAS multiframe 2
        tick();
        check("r5_wait", 32'(link_phase), 32'(PH_WAIT));
        wait_lmfc(0);
        check("r5_ilas", 32'(link_phase), 32'(PH_ILAS));
        repeat (69) tick();
        check("r5_mf2", 32'(link_phase), 32'(PH_ILAS));
        #2;
        reset = 1'b1; sync_n = 1'b0;
        #1;
        check("arst_phase", 32'(link_phase), 32'(PH_CGS));
        check("arst_k", 32'(k_char_en), 32'd1);
        check("arst_tpl", 32'(tpl_en), 32'd0);
        check("arst_lmfc", 32'(lmfc_cnt), 32'd0);
        check("arst_resync", 32'(resync_cnt), 32'd0);
        check("arst_ilas", {29'd0, ilas_r, ilas_a, ilas_q}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; frame = 0;

        // Sync seen in CGS on the last frame: full multiframe in WAIT
        wait_lmfc(29);
        sync_n = 1'b1;
        tick(); tick();
        check("edge_cgs", 32'(link_phase), 32'(PH_CGS));
        tick();
        check("edge_wait0", 32'(link_phase), 32'(PH_WAIT));
        wait_lmfc(31);
        check("edge_wait31", 32'(link_phase), 32'(PH_WAIT));
        tick();
        check("edge_ilas", 32'(link_phase), 32'(PH_ILAS));

`ifdef JESD_TX_SYSREF_EN
        // 6: SYSREF edge mid-ILAS restarts the sequence
        repeat (42) tick();
        sysref = 1'b1; tick();
        sysref = 1'b0; tick(); tick();
        check("sref_ilas_lmfc", 32'(lmfc_cnt), 32'd0);
        check("sref_ilas_phase", 32'(link_phase), 32'(PH_ILAS));
        check("sref_ilas_resync", 32'(resync_cnt), 32'd0);
        frame = 0;
`endif
        repeat (127) tick();
        check("end_tpl", 32'(tpl_en), 32'd1);
        check("end_ilas", 32'(link_phase), 32'(PH_ILAS));
        tick();
        check("end_data", 32'(link_phase), 32'(PH_DATA));
`ifdef JESD_TX_SYSREF_EN
        wait_lmfc(17);
        sysref = 1'b1; tick();
        sysref = 1'b0; tick(); tick();
        check("sref_lmfc", 32'(lmfc_cnt), 32'd0);
        frame = 0;
`endif
        check("end_resync", 32'(resync_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
